gray_to_bin: RTL and testbench
==============================

# gray_to_bin

Gray-code to binary converter used on pointer paths of the asynchronous FIFO. It provides a purely combinational conversion of the input Gray word, and a registered path. The registered path synchronizes the Gray word into the local clock domain, converts it, and flags illegal multi-bit Gray transitions. It sits on the receiving side of a Gray-coded pointer crossing, for example the write pointer into the read domain.

## Interface
Parameters:
- WIDTH, default 4: bit width of the Gray and binary words; legal range 2 to 32.
- SYNC_STAGES, default 2: number of synchronizer flops on the registered path; legal range 1 to 4.

Ports:
- clk  input  1  local-domain clock. One clock; all flops are rising-edge.
- rst_n  input  1  asynchronous active-low reset; all flops clear immediately when low.
- gray_in  input  WIDTH  Gray-coded word; may be asynchronous to clk.
- binary_out  output  WIDTH  combinational binary equivalent of gray_in.
- gray_sync  output  WIDTH  gray_in after the SYNC_STAGES synchronizer.
- binary_q  output  WIDTH  registered binary equivalent of gray_sync.
- gray_err  output  1  one-cycle pulse when successive gray_sync values differ in more than one bit.

## Operation
Conversion rule, applied identically on both paths:
- b[WIDTH-1] = g[WIDTH-1].
- b[i] = b[i+1] XOR g[i], for i from WIDTH-2 down to 0.
- Equivalently, b[i] is the XOR of g[WIDTH-1:i].

Combinational path:
- binary_out depends only on gray_in.
- No clock or reset dependence; it updates in the same delta in which gray_in changes.

Synchronizer:
- A chain of SYNC_STAGES flops, each WIDTH bits wide.
- Stage 0 samples gray_in; stage k samples stage k-1.
- gray_sync is the last stage.
- No logic between stages.

Registered conversion:
- binary_q is a flop loaded every cycle with convert(gray_sync).

Error check:
- A flop holds the previous gray_sync.
- gray_err is registered and asserts for one cycle when popcount(gray_sync XOR previous) > 1.
- A change of 0 bits or 1 bit never asserts gray_err.
- gray_err is not sticky.

Reset:
- All synchronizer stages, the previous-value flop, binary_q and gray_err clear to 0.
- binary_out is unaffected by reset.
- Reset asserted mid-operation clears the registered state on the falling edge of rst_n, with no wait for clk.
- The first comparison after reset is made against 0.

## Timing
- binary_out has zero-cycle latency.
- After a gray_in change that is stable across the sampling edge, gray_sync reflects it SYNC_STAGES rising edges later.
- binary_q reflects it SYNC_STAGES+1 edges later.
- gray_err is valid SYNC_STAGES+1 edges after the offending input step.
- With reset release and the default SYNC_STAGES=2: gray_sync, binary_q and gray_err are all 0 until data propagates.
- Wrap-around from Gray 100...0 to 000...0 is a single-bit change and does not raise gray_err.
- A non-Gray jump (for example 0 to 3) raises gray_err once.
- The chain still follows the new value and converts it normally.

## Test plan
- Combinational sweep, WIDTH=4: drive gray_in 0..15, each held for at least 10 ns. Expect binary_out = 0,1,3,2,7,6,4,5,15,14,12,13,8,9,11,10.
- Registered latency, SYNC_STAGES=2: step gray_in from 0 to 4'b0110 after reset. Expect gray_sync = 6 after 2 edges, and binary_q = 4 after 3 edges.
- Gray counting sequence: drive a 4-bit Gray counter through 0 to 15 and wrap back to 0, one step per clk. Expect binary_q to track 0..15 then 0, and gray_err to stay 0 throughout.
- Illegal jump: step gray_in from 0 to 4'b0011. Expect gray_err = 1 for exactly one cycle at edge 3, with binary_q = 2.
- Asynchronous reset mid-stream: pull rst_n low between clock edges while gray_sync = 9. Expect gray_sync, binary_q and gray_err = 0 immediately, while binary_out still equals convert(gray_in).
- Width scaling, WIDTH=8: drive gray_in = 8'h80. Expect binary_out = 8'hFF, and binary_q = 8'hFF after 3 edges.

Source files
------------

// File: rtl/gray_to_bin.sv
// gray_to_bin
// Gray-code to binary converter for the receiving side of a Gray-coded
// pointer crossing (for example the write pointer seen in the read domain).
//
// Ports:
//   clk        in   1      local-domain clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   gray_in    in   WIDTH  Gray word, may be asynchronous to clk
//   binary_out out  WIDTH  combinational binary equivalent of gray_in
//   gray_sync  out  WIDTH  gray_in after the SYNC_STAGES synchronizer
//   binary_q   out  WIDTH  registered binary equivalent of gray_sync
//   gray_err   out  1      one-cycle pulse when successive gray_sync values
//                          differ in more than one bit
module gray_to_bin #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] binary_out,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] binary_q,
  output logic             gray_err
);

  // b[i] is the XOR of g[WIDTH-1:i]; built MSB-first as a running XOR.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = {WIDTH{1'b0}};
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit of d is set: clearing the lowest set bit
  // leaves something behind only if a second bit was set.
  function automatic logic multi_bit(input logic [WIDTH-1:0] d);
    return |(d & (d - {{(WIDTH-1){1'b0}}, 1'b1}));
  endfunction

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] binary_q_r;
  logic             gray_err_r;
  logic [WIDTH-1:0] binary_out_s;
  logic             err_next_s;

  // Combinational conversion of the raw input; no clock or reset involvement.
  always_comb begin
    binary_out_s = gray2bin(gray_in);
  end

  // Error decision compares the current synchronized word with the one before.
  always_comb begin
    err_next_s = multi_bit(sync_r[SYNC_STAGES-1] ^ prev_r);
  end

  // Synchronizer chain: plain flop-to-flop, no logic between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_r[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Registered conversion, previous-value tracking and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r     <= {WIDTH{1'b0}};
      binary_q_r <= {WIDTH{1'b0}};
      gray_err_r <= 1'b0;
    end else begin
      prev_r     <= sync_r[SYNC_STAGES-1];
      binary_q_r <= gray2bin(sync_r[SYNC_STAGES-1]);
      gray_err_r <= err_next_s;
    end
  end

  assign binary_out = binary_out_s;
  assign gray_sync  = sync_r[SYNC_STAGES-1];
  assign binary_q   = binary_q_r;
  assign gray_err   = gray_err_r;

endmodule

// File: tb/tb_gray_to_bin.sv
module tb_gray_to_bin;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic [3:0] binary_out;
  logic [3:0] gray_sync;
  logic [3:0] binary_q;
  logic       gray_err;

  logic [7:0] gray_in8;
  logic [7:0] binary_out8;
  logic [7:0] gray_sync8;
  logic [7:0] binary_q8;
  logic       gray_err8;

  int passed;
  int total;

  gray_to_bin #(.WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .binary_out (binary_out),
    .gray_sync  (gray_sync),
    .binary_q   (binary_q),
    .gray_err   (gray_err)
  );

  gray_to_bin #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in8),
    .binary_out (binary_out8),
    .gray_sync  (gray_sync8),
    .binary_q   (binary_q8),
    .gray_err   (gray_err8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    gray_in  = 4'd0;
    gray_in8 = 8'd0;
    #22;
    total++;
    if (gray_sync !== 4'd0 || binary_q !== 4'd0 || gray_err !== 1'b0) begin
      $display("FAIL reset_state: sync=%0d q=%0d err=%0b want 0/0/0", gray_sync, binary_q, gray_err);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      total++;
      if (gray_sync !== 4'd0 || binary_q !== 4'd0 || gray_err !== 1'b0) begin
        $display("FAIL post_reset_idle[%0d]: sync=%0d q=%0d err=%0b want 0/0/0", i, gray_sync, binary_q, gray_err);
      end else passed++;
    end
  endtask

  task automatic test_comb_sweep();
    logic [3:0] exp_tab [16];
    exp_tab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd4, 4'd5,
                4'd15, 4'd14, 4'd12, 4'd13, 4'd8, 4'd9, 4'd11, 4'd10};
    for (int i = 0; i < 16; i++) begin
      gray_in = 4'(i);
      #10;
      total++;
      if (binary_out !== exp_tab[i]) begin
        $display("FAIL comb_sweep g=%0d: got %0d want %0d", i, binary_out, exp_tab[i]);
      end else passed++;
    end
    // return to 0 and let the pipeline settle (err pulse from the sweep drains)
    @(negedge clk);
    gray_in = 4'd0;
    repeat (6) edge_sample();
  endtask

  task automatic test_latency();
    @(negedge clk);
    gray_in = 4'b0110;
    edge_sample();
    total++;
    if (gray_sync !== 4'd0) begin
      $display("FAIL latency_edge1_sync: got %0d want 0", gray_sync);
    end else passed++;
    edge_sample();
    total++;
    if (gray_sync !== 4'd6) begin
      $display("FAIL latency_edge2_sync: got %0d want 6", gray_sync);
    end else passed++;
    total++;
    if (binary_q !== 4'd0) begin
      $display("FAIL latency_edge2_q: got %0d want 0", binary_q);
    end else passed++;
    edge_sample();
    total++;
    if (binary_q !== 4'd4) begin
      $display("FAIL latency_edge3_q: got %0d want 4", binary_q);
    end else passed++;
    @(negedge clk);
    gray_in = 4'd0;
    repeat (6) edge_sample();
  endtask

  task automatic test_counting();
    logic [3:0] seq [17];
    logic [3:0] exp_q;
    seq = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
            4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
    for (int m = 0; m < 19; m++) begin
      @(negedge clk);
      gray_in = seq[(m < 16) ? m : 16];
      edge_sample();
      if (m < 2) exp_q = 4'd0;
      else if (m - 2 == 16) exp_q = 4'd0;
      else exp_q = 4'(m - 2);
      total++;
      if (binary_q !== exp_q) begin
        $display("FAIL count_q[%0d]: got %0d want %0d", m, binary_q, exp_q);
      end else passed++;
      total++;
      if (gray_err !== 1'b0) begin
        $display("FAIL count_err[%0d]: got %0b want 0", m, gray_err);
      end else passed++;
    end
    repeat (3) edge_sample();
  endtask

  task automatic test_illegal_jump();
    logic exp_err [4];
    exp_err = '{1'b0, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    gray_in = 4'b0011;
    for (int e = 0; e < 4; e++) begin
      edge_sample();
      total++;
      if (gray_err !== exp_err[e]) begin
        $display("FAIL jump_err_edge%0d: got %0b want %0b", e + 1, gray_err, exp_err[e]);
      end else passed++;
      if (e == 2) begin
        total++;
        if (binary_q !== 4'd2) begin
          $display("FAIL jump_q_edge3: got %0d want 2", binary_q);
        end else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    gray_in = 4'd9;
    repeat (3) edge_sample();
    total++;
    if (gray_sync !== 4'd9) begin
      $display("FAIL areset_pre_sync: got %0d want 9", gray_sync);
    end else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (gray_sync !== 4'd0 || binary_q !== 4'd0 || gray_err !== 1'b0) begin
      $display("FAIL areset_clear: sync=%0d q=%0d err=%0b want 0/0/0", gray_sync, binary_q, gray_err);
    end else passed++;
    total++;
    if (binary_out !== 4'd14) begin
      $display("FAIL areset_comb: got %0d want 14", binary_out);
    end else passed++;
    gray_in = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) edge_sample();
  endtask

  task automatic test_width8();
    @(negedge clk);
    gray_in8 = 8'h80;
    #1;
    total++;
    if (binary_out8 !== 8'hFF) begin
      $display("FAIL w8_comb: got %h want ff", binary_out8);
    end else passed++;
    repeat (2) edge_sample();
    total++;
    if (binary_q8 !== 8'h00) begin
      $display("FAIL w8_q_edge2: got %h want 00", binary_q8);
    end else passed++;
    edge_sample();
    total++;
    if (binary_q8 !== 8'hFF) begin
      $display("FAIL w8_q_edge3: got %h want ff", binary_q8);
    end else passed++;
    total++;
    if (gray_err8 !== 1'b0) begin
      $display("FAIL w8_err: got %0b want 0", gray_err8);
    end else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_comb_sweep();
    test_latency();
    test_counting();
    test_illegal_jump();
    test_async_reset();
    test_width8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
